multicycle_control: RTL and testbench
=====================================

# multicycle_control

- Parametrised multicycle control unit for the RV32I datapath.
- Replaces the fixed start/done controller with an opcode-decoding FSM.
- Adds an instruction budget, halt on ECALL, a retired-instruction counter and optional illegal-opcode trapping.
- Sits between the top-level run handshake (start/done) and the datapath, which it drives with per-state control strobes.

## Interface
- INSTR_LIMIT, 64: instructions retired before a forced halt; 0 = unlimited.
- CNT_W, 16: width of instr_count; must satisfy INSTR_LIMIT < 2^CNT_W.
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level run request; sampled only in IDLE.
- opcode  in  7  IR[6:0] from the datapath, valid from DECODE onward.
- funct3  in  3  IR[14:12].
- zero  in  1  ALU zero flag, valid in EXEC.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high only in DONE.
- err  out  1  illegal opcode trapped; sticky until IDLE.
- pc_write  out  1  PC load strobe.
- pc_src  out  1  0 = PC+4, 1 = ALU result/target.
- ir_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4, 11 immediate (LUI).
- instr_count  out  CNT_W  instructions retired since the last IDLE→FETCH transition.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
- IDLE: start=1 → FETCH, clears instr_count and err.
- FETCH: mem_read=1, ir_write=1, pc_write=1, pc_src=0 → DECODE.
- DECODE: no strobes; routing on opcode:
  - ECALL (1110011) → DONE; counts as retired.
  - R-type (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011, funct3 000 or 001 only), JAL (1101111), LUI (0110111) → EXEC.
  - Anything else, including BRANCH with other funct3 values, is illegal (see Configuration).
- EXEC strobes and next state:
  - R-type: alu_op=10 → WB.
  - I-ALU: alu_op=10 → WB.
  - LOAD/STORE: alu_op=00 → MEM.
  - BRANCH: alu_op=01; pc_write = zero XOR funct3[0]; pc_src=1; instruction ends.
  - JAL: pc_write=1, pc_src=1 → WB.
  - LUI: no strobes → WB.
- MEM:
  - LOAD: mem_read=1 → WB.
  - STORE: mem_write=1; instruction ends.
- WB: reg_write=1; wb_sel = 00 for R/I-ALU, 01 for LOAD, 10 for JAL, 11 for LUI; instruction ends.
- Instruction end:
  - instr_count increments by 1, saturating at 2^CNT_W−1.
  - If INSTR_LIMIT≠0 and the incremented count equals INSTR_LIMIT → DONE; else → FETCH.
- DONE: done=1; stays until start=0, then → IDLE. A start held high never re-triggers a run.
- start changes outside IDLE/DONE are ignored.
- All strobes not listed for a state are 0.

## Timing
- Reset: state=IDLE; every output 0, including instr_count and err. A reset mid-instruction aborts with no further strobes on the next cycle.
- Cycles per instruction:
  - BRANCH 3
  - R, I-ALU, STORE, JAL, LUI 4
  - LOAD 5
  - ECALL 2 (FETCH, DECODE) then DONE
- Latency start→first FETCH: 1 cycle. done asserts the cycle after the terminating state.
- instr_count updates on the same edge that leaves the final state of an instruction.
- rst and start asserted in the same cycle: rst wins.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - Illegal opcode in DECODE → DONE with err=1 in the same transition.
  - The instruction is not counted.
  - err stays 1 until the next IDLE→FETCH transition.
- Undefined:
  - Illegal opcode is a NOP: DECODE → FETCH, counted as retired, subject to the limit check.
  - err is tied to 0.

## Test plan
- Reset then start=1, IR stream R,LOAD,STORE,BRANCH(beq, zero=1),JAL,LUI,ECALL → cycles 4,5,4,3,4,4,2; instr_count=7; done=1 at cycle 27 after start; pc_write=1 in the beq EXEC.
- bne with zero=1 → pc_write=0 in EXEC; next state FETCH.
- INSTR_LIMIT=3, endless R-type → done after exactly 12 cycles of run; instr_count=3; start held 1 keeps DONE; start=0 → IDLE next cycle.
- Opcode 0000000:
  - with ILLEGAL_TRAP_EN: DONE, err=1, instr_count unchanged.
  - without: 2-cycle NOP, count +1, err=0.
- rst=1 during a LOAD's MEM state → next cycle IDLE; all strobes, done, err and instr_count 0; a fresh start runs normally.
- INSTR_LIMIT=0, CNT_W=4, 20 R-type then ECALL → instr_count saturates at 15; done only on the ECALL.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: opcode decode, per-state datapath strobes, instruction budget, ECALL halt.
// Latency: start to first FETCH 1 cycle; 2-5 cycles per instruction. Handshake: level start, done held until start drops.
// Optional illegal-opcode trap is enabled by defining ILLEGAL_TRAP_EN; otherwise illegal opcodes retire as NOPs.
module multicycle_control #(
    parameter int INSTR_LIMIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic             i_zero,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_pc_write,
    output logic             o_pc_src,
    output logic             o_ir_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_reg_write,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_wb_sel,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(INSTR_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI
    } cls_t;

    state_t          r_state, w_next;
    cls_t            r_cls, w_cls;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic            w_legal;
    logic            w_ecall;
    logic            w_limit_hit;
    logic            w_retire;
    logic            w_run_start;
    state_t          w_end_next;
`ifdef ILLEGAL_TRAP_EN
    logic            w_trap;
    logic            r_err;
`endif

    // Opcode classification; the class is latched in DECODE so later states need not re-decode.
    always_comb begin
        w_legal = 1'b1;
        w_cls   = C_ALU;
        w_ecall = (i_opcode == OP_ECALL);
        case (i_opcode)
            OP_R, OP_I: w_cls = C_ALU;
            OP_LOAD:    w_cls = C_LOAD;
            OP_STORE:   w_cls = C_STORE;
            OP_BRANCH: begin
                w_cls   = C_BRANCH;
                w_legal = (i_funct3[2:1] == 2'b00);
            end
            OP_JAL:     w_cls = C_JAL;
            OP_LUI:     w_cls = C_LUI;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_limit_hit = (INSTR_LIMIT != 0) && (w_cnt_inc == LIMIT_V);
    assign w_end_next  = w_limit_hit ? S_DONE : S_FETCH;

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_run_start = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_trap      = 1'b0;
`endif
        o_pc_write  = 1'b0;
        o_pc_src    = 1'b0;
        o_ir_write  = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_reg_write = 1'b0;
        o_alu_op    = 2'b00;
        o_wb_sel    = 2'b00;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next      = S_FETCH;
                    w_run_start = 1'b1;
                end
            end
            S_FETCH: begin
                o_mem_read = 1'b1;
                o_ir_write = 1'b1;
                o_pc_write = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                if (w_ecall) begin
                    w_retire = 1'b1;
                    w_next   = S_DONE;
                end else if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_trap = 1'b1;
                    w_next = S_DONE;
`else
                    w_retire = 1'b1;
                    w_next   = w_end_next;
`endif
                end
            end
            S_EXEC: begin
                case (r_cls)
                    C_ALU: begin
                        o_alu_op = 2'b10;
                        w_next   = S_WB;
                    end
                    C_LOAD, C_STORE: w_next = S_MEM;
                    C_BRANCH: begin
                        // funct3[0] selects bne, which takes the branch when zero is clear
                        o_alu_op   = 2'b01;
                        o_pc_write = i_zero ^ i_funct3[0];
                        o_pc_src   = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = w_end_next;
                    end
                    C_JAL: begin
                        o_pc_write = 1'b1;
                        o_pc_src   = 1'b1;
                        w_next     = S_WB;
                    end
                    C_LUI:   w_next = S_WB;
                    default: w_next = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (r_cls == C_LOAD) begin
                    o_mem_read = 1'b1;
                    w_next     = S_WB;
                end else begin
                    o_mem_write = 1'b1;
                    w_retire    = 1'b1;
                    w_next      = w_end_next;
                end
            end
            S_WB: begin
                o_reg_write = 1'b1;
                case (r_cls)
                    C_LOAD:  o_wb_sel = 2'b01;
                    C_JAL:   o_wb_sel = 2'b10;
                    C_LUI:   o_wb_sel = 2'b11;
                    default: o_wb_sel = 2'b00;
                endcase
                w_retire = 1'b1;
                w_next   = w_end_next;
            end
            S_DONE: begin
                o_done = 1'b1;
                if (!i_start) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cls   <= C_ALU;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
            end
            if (w_run_start) begin
                r_cnt <= '0;
            end else if (w_retire) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_run_start) begin
            r_err <= 1'b0;
        end else if (w_trap) begin
            r_err <= 1'b1;
        end
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_instr_count = r_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: three instances (default, INSTR_LIMIT=3, CNT_W=4 unlimited),
// directed instruction streams fed through a small IR model.
module tb_multicycle_control;

    typedef struct packed {
        logic [31:0] off;
        logic [28:0] w;
    } exp_t;

    typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_LUI, K_ECALL, K_ILL, K_BADBR} kind_e;

    localparam logic [9:0] X_FETCH = 10'b1011000000;
    localparam logic [9:0] X_NONE  = 10'b0000000000;
    localparam logic [9:0] X_ALU   = 10'b0000001000;
    localparam logic [9:0] X_JAL   = 10'b1100000000;
    localparam logic [9:0] X_MRD   = 10'b0001000000;
    localparam logic [9:0] X_MWR   = 10'b0000100000;
    localparam logic [9:0] X_WB    = 10'b0000010000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [6:0] op [3];
    logic [2:0] f3 [3];
    logic       z  [3];
    logic       busy [3], done [3], err [3], pw [3], ps [3], irw [3], mr [3], mw [3], rw [3];
    logic [1:0] alu [3], wb [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc [3];
    int   ecnt [3];
    int   emax [3];
    int   eoff [3];
    logic eerr [3];
    logic [10:0] dflt [3];
    exp_t q0 [$], q1 [$], q2 [$];
    logic [10:0] pq0 [$], pq1 [$], pq2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_control #(.INSTR_LIMIT(64), .CNT_W(16)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_opcode(op[0]), .i_funct3(f3[0]), .i_zero(z[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]), .o_pc_write(pw[0]), .o_pc_src(ps[0]),
        .o_ir_write(irw[0]), .o_mem_read(mr[0]), .o_mem_write(mw[0]), .o_reg_write(rw[0]),
        .o_alu_op(alu[0]), .o_wb_sel(wb[0]), .o_instr_count(cnt0));

    multicycle_control #(.INSTR_LIMIT(3), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_opcode(op[1]), .i_funct3(f3[1]), .i_zero(z[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]), .o_pc_write(pw[1]), .o_pc_src(ps[1]),
        .o_ir_write(irw[1]), .o_mem_read(mr[1]), .o_mem_write(mw[1]), .o_reg_write(rw[1]),
        .o_alu_op(alu[1]), .o_wb_sel(wb[1]), .o_instr_count(cnt1));

    multicycle_control #(.INSTR_LIMIT(0), .CNT_W(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_opcode(op[2]), .i_funct3(f3[2]), .i_zero(z[2]),
        .o_busy(busy[2]), .o_done(done[2]), .o_err(err[2]), .o_pc_write(pw[2]), .o_pc_src(ps[2]),
        .o_ir_write(irw[2]), .o_mem_read(mr[2]), .o_mem_write(mw[2]), .o_reg_write(rw[2]),
        .o_alu_op(alu[2]), .o_wb_sel(wb[2]), .o_instr_count(cnt2));

    function automatic logic [28:0] obs(int i);
        logic [15:0] c;
        c = (i == 0) ? cnt0 : (i == 1) ? cnt1 : {12'd0, cnt2};
        return {busy[i], done[i], err[i], pw[i], ps[i], irw[i], mr[i], mw[i], rw[i], alu[i], wb[i], c};
    endfunction

    task automatic chk(string name, int inst, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h", name, inst, got, exp);
        end
    endtask

    function automatic int qsize(int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic push_word(int i, logic b, logic d, logic [9:0] s);
        exp_t e;
        eoff[i]++;
        e.off = eoff[i];
        e.w   = {b, d, eerr[i], s, 16'(ecnt[i])};
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pwd(int i, logic [9:0] s);
        push_word(i, 1'b1, 1'b0, s);
    endtask

    task automatic retire(int i);
        if (ecnt[i] < emax[i]) ecnt[i]++;
    endtask

    task automatic begin_run(int i);
        ecnt[i] = 0;
        eerr[i] = 1'b0;
        eoff[i] = 0;
        case (i)
            0: pq0.delete();
            1: pq1.delete();
            default: pq2.delete();
        endcase
    endtask

    // Queue one instruction into the IR model and its expected per-cycle strobes into the scoreboard.
    task automatic add(int i, kind_e k, logic [2:0] fn = 3'b000, logic zz = 1'b0);
        logic [6:0] opc;
        logic       counted;
        counted = 1'b1;
        opc     = 7'b1110011;
        pwd(i, X_FETCH);
        pwd(i, X_NONE);
        case (k)
            K_R:     begin opc = 7'b0110011; pwd(i, X_ALU); pwd(i, X_WB); end
            K_I:     begin opc = 7'b0010011; pwd(i, X_ALU); pwd(i, X_WB); end
            K_LD:    begin opc = 7'b0000011; pwd(i, X_NONE); pwd(i, X_MRD); pwd(i, X_WB | 10'b01); end
            K_ST:    begin opc = 7'b0100011; pwd(i, X_NONE); pwd(i, X_MWR); end
            K_BR:    begin opc = 7'b1100011; pwd(i, {zz ^ fn[0], 9'b100000100}); end
            K_JAL:   begin opc = 7'b1101111; pwd(i, X_JAL); pwd(i, X_WB | 10'b10); end
            K_LUI:   begin opc = 7'b0110111; pwd(i, X_NONE); pwd(i, X_WB | 10'b11); end
            K_ECALL: opc = 7'b1110011;
            K_ILL, K_BADBR: begin
                opc = (k == K_ILL) ? 7'b0000000 : 7'b1100011;
`ifdef ILLEGAL_TRAP_EN
                counted = 1'b0;
                eerr[i] = 1'b1;
`endif
            end
            default: opc = 7'b1110011;
        endcase
        if (counted) retire(i);
        case (i)
            0: pq0.push_back({zz, fn, opc});
            1: pq1.push_back({zz, fn, opc});
            default: pq2.push_back({zz, fn, opc});
        endcase
    endtask

    task automatic push_done(int i, int n);
        for (int j = 0; j < n; j++) push_word(i, 1'b0, 1'b1, X_NONE);
    endtask

    // Raise start, wait (bounded) for done, hold start ndone cycles in DONE, then drop and expect IDLE.
    task automatic go(int i, int ndone, logic with_rst = 1'b0);
        int n;
        @(negedge clk);
        start[i] = 1'b1;
        if (with_rst) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_wins_busy", i, 64'(busy[i]), 64'd0);
            rst = 1'b0;
        end
        start_cyc[i] = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < 400);
        chk("done_seen", i, 64'(done[i]), 64'd1);
        repeat (ndone - 1) @(negedge clk);
        start[i] = 1'b0;
        @(negedge clk);
        chk("idle_after_done", i, 64'({busy[i], done[i]}), 64'd0);
        chk("scoreboard_drained", i, 64'(qsize(i)), 64'd0);
    endtask

    // IR model: the instruction register loads on the FETCH cycle.
    initial begin
        logic [10:0] v;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (irw[i]) begin
                    v = dflt[i];
                    case (i)
                        0: if (pq0.size() > 0) v = pq0.pop_front();
                        1: if (pq1.size() > 0) v = pq1.pop_front();
                        default: if (pq2.size() > 0) v = pq2.pop_front();
                    endcase
                    op[i] = v[6:0];
                    f3[i] = v[9:7];
                    z[i]  = v[10];
                end
            end
        end
    end

    // Monitor: every cycle an instance is busy or done must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (busy[i] || done[i]) begin
                    if (qsize(i) == 0) begin
                        chk("unexpected_output", i, {3'b0, 32'(cyc - start_cyc[i]), obs(i)}, 64'd0);
                    end else begin
                        e = qpop(i);
                        chk("cycle_word", i, {3'b0, 32'(cyc - start_cyc[i]), obs(i)}, {3'b0, e.off, e.w});
                    end
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 3'b000;
        for (int i = 0; i < 3; i++) begin
            op[i] = 7'd0; f3[i] = 3'd0; z[i] = 1'b0; start_cyc[i] = 0;
            ecnt[i] = 0; eoff[i] = 0; eerr[i] = 1'b0;
        end
        emax[0] = 65535; emax[1] = 65535; emax[2] = 15;
        dflt[0] = {4'b0, 7'b1110011};
        dflt[1] = {4'b0, 7'b0110011};
        dflt[2] = {4'b0, 7'b1110011};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset_outputs", i, 64'(obs(i)), 64'd0);
        rst = 1'b0;

        // Mixed program: 4,5,4,3,4,4,2 cycles, done at offset 27 with count 7.
        begin_run(0);
        add(0, K_R); add(0, K_LD); add(0, K_ST); add(0, K_BR, 3'b000, 1'b1);
        add(0, K_JAL); add(0, K_LUI); add(0, K_ECALL);
        push_done(0, 1);
        go(0, 1);

        // bne with zero set does not branch; then an illegal opcode.
        begin_run(0);
        add(0, K_BR, 3'b001, 1'b1); add(0, K_I); add(0, K_ILL);
`ifndef ILLEGAL_TRAP_EN
        add(0, K_ECALL);
`endif
        push_done(0, 1);
        go(0, 1);

        // Branch with an unsupported funct3 is illegal.
        begin_run(0);
        add(0, K_BADBR, 3'b100, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        add(0, K_ECALL);
`endif
        push_done(0, 2);
        go(0, 2);

        // Reset during a LOAD's MEM state aborts the run.
        begin_run(0);
        pq0.push_back({4'b0, 7'b0000011});
        pwd(0, X_FETCH); pwd(0, X_NONE); pwd(0, X_NONE); pwd(0, X_MRD);
        @(negedge clk);
        start[0]     = 1'b1;
        start_cyc[0] = cyc;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start[0] = 1'b0;
        chk("reset_abort_outputs", 0, 64'(obs(0)), 64'd0);
        chk("reset_abort_drained", 0, 64'(qsize(0)), 64'd0);

        // Fresh run after reset, starting with rst and start raised together.
        begin_run(0);
        add(0, K_R); add(0, K_ECALL);
        push_done(0, 1);
        go(0, 1, 1'b1);

        // Budget of 3 with an endless R-type stream; start held keeps DONE.
        begin_run(1);
        add(1, K_R); add(1, K_R); add(1, K_R);
        push_done(1, 4);
        go(1, 4);

        // 4-bit counter saturates at 15; only the ECALL ends the run.
        begin_run(2);
        for (int j = 0; j < 20; j++) add(2, K_R);
        add(2, K_ECALL);
        push_done(2, 1);
        go(2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
